// File: rtl/qam_sched_pkg.sv
// Shared constants and state encoding for the QAM-16 burst scheduler.
package qam_sched_pkg;

  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned DEF_SYM_W  = 4;
  localparam int unsigned UCNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/qam_tick_counter.sv
// Loadable terminal-count counter; shared between symbol-period timing and gap countdown.
module qam_tick_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  assign tick_c = en && (cnt == terminal);

  // Wraps to zero on terminal count so the next period starts immediately
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/qam_burst_scheduler.sv
// Timed-burst QAM-16 symbol scheduler between mapper FIFO and modulator.
// Optional QAM_SCHED_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module qam_burst_scheduler
  import qam_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned SYM_W = DEF_SYM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [LEN_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic             cfg_repeat,
  input  logic             start,
  input  logic             abort,
  input  logic [SYM_W-1:0] s_sym,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [SYM_W-1:0] m_sym,
  output logic             m_valid,
  output logic             underflow,
  output logic             busy,
  output logic             done
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
  ,
  output logic [UCNT_W-1:0] underflow_cnt
`endif
);

  state_t           state, next_state;
  logic [CNT_W-1:0] period_q, gap_q, terminal_c;
  logic [LEN_W-1:0] len_q, sym_cnt;
  logic             repeat_q;
  logic             tick_c, slot_c, last_c, start_ok_c;
  logic             cnt_en_c, cnt_clear_c;

  assign start_ok_c = (state == ST_IDLE) && start && !abort;
  assign slot_c     = (state == ST_RUN) && tick_c && !abort;
  assign last_c     = (sym_cnt == len_q - LEN_W'(1));
  assign s_ready    = slot_c;

  qam_tick_counter #(.W(CNT_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear_c),
    .en       (cnt_en_c),
    .terminal (terminal_c),
    .tick_c   (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    cnt_en_c    = (state == ST_RUN) || (state == ST_GAP);
    terminal_c  = (state == ST_GAP) ? gap_q - CNT_W'(1) : period_q - CNT_W'(1);
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start_ok_c) next_state = (cfg_burst_len == '0) ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (slot_c && last_c) begin
            if (!repeat_q)          next_state = ST_DONE;
            else if (gap_q != '0)   next_state = ST_GAP;
          end
        end
        ST_GAP:  if (tick_c) next_state = ST_RUN;
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
    // Each state entry restarts the shared counter from zero
    cnt_clear_c = (next_state != state) || !cnt_en_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= CNT_W'(1);
      gap_q    <= '0;
      len_q    <= '0;
      repeat_q <= 1'b0;
    end else if (start_ok_c) begin
      period_q <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
      gap_q    <= cfg_gap;
      len_q    <= cfg_burst_len;
      repeat_q <= cfg_repeat;
    end
  end

  // Slot counter: underflow slots still consume a position in the burst
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (slot_c) begin
      sym_cnt <= last_c ? '0 : sym_cnt + LEN_W'(1);
    end else if (abort || (state != ST_RUN)) begin
      sym_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_sym     <= '0;
      underflow <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      m_valid   <= slot_c;
      underflow <= slot_c && !s_valid;
      if (slot_c) begin
        m_sym <= s_valid ? s_sym : '0;
      end
      done      <= (state == ST_DONE) && !abort;
      busy      <= (next_state != ST_IDLE);
    end
  end

`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok_c) begin
      underflow_cnt <= '0;
    end else if (underflow && (underflow_cnt != '1)) begin
      underflow_cnt <= underflow_cnt + UCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_qam_burst_scheduler.sv
// Self-checking bench for qam_burst_scheduler: vector table plus scoreboard of expected symbols.
module tb_qam_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_period;
  logic [15:0] cfg_burst_len;
  logic [31:0] cfg_gap;
  logic        cfg_repeat;
  logic        start, abort;
  logic [3:0]  s_sym;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  m_sym;
  logic        m_valid, underflow, busy, done;
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  qam_burst_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_period    (cfg_period),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .cfg_repeat    (cfg_repeat),
    .start         (start),
    .abort         (abort),
    .s_sym         (s_sym),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_sym         (m_sym),
    .m_valid       (m_valid),
    .underflow     (underflow),
    .busy          (busy),
    .done          (done)
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  typedef struct {
    int          period;
    int          len;
    bit          rep;
    int          gap;
    logic [7:0]  mask;
    logic [31:0] syms;
    int          abort_cyc;
    int          poke_cyc;
    int          ncyc;
  } vec_t;

  typedef struct packed {
    logic [3:0] sym;
    logic       uf;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle 0 carries the start pulse; the loop samples cycle c at #1 after its opening edge
  task automatic run(input vec_t v);
    int   p, np, b, r1, k, end_c, done_c, n, nuf;
    logic exp_tick;
    exp_t e;
    p  = (v.period == 0) ? 1 : v.period;
    np = v.len * p;
    b  = (np + v.gap > 0) ? np + v.gap : 1;
    if (v.abort_cyc == 0) begin
      end_c = 1; done_c = -1;
    end else if (!v.rep) begin
      end_c = np + 2; done_c = np + 2;
      if (v.abort_cyc > 0 && v.abort_cyc <= np + 1) begin
        end_c = v.abort_cyc + 1; done_c = -1;
      end
    end else begin
      end_c = v.abort_cyc + 1; done_c = -1;
    end
    n   = (v.ncyc > 0) ? v.ncyc : end_c + 3;
    nuf = 0;
    sbq.delete();

    cfg_period    = 32'(v.period);
    cfg_burst_len = 16'(v.len);
    cfg_gap       = 32'(v.gap);
    cfg_repeat    = v.rep;
    start   = 1'b1;
    abort   = (v.abort_cyc == 0);
    s_valid = 1'b0;
    s_sym   = 4'h0;
    @(posedge clk); #1;

    for (int c = 1; c <= n; c++) begin
      check("m_valid", 32'(m_valid), 32'(sbq.size() > 0));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("m_sym", 32'(m_sym), 32'(e.sym));
        check("underflow", 32'(underflow), 32'(e.uf));
      end else begin
        check("underflow_idle", 32'(underflow), 32'(0));
      end
      check("busy", 32'(busy), 32'(c < end_c));
      check("done", 32'(done), 32'(c == done_c));
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
      if (c == 1 && v.abort_cyc != 0) check("ucnt_clear", 32'(underflow_cnt), 32'(0));
`endif
      abort = (c == v.abort_cyc);
      start = (c == v.poke_cyc);
      if (c == v.poke_cyc) begin
        cfg_period = 32'd1; cfg_burst_len = 16'd9; cfg_repeat = 1'b1; cfg_gap = 32'd0;
      end
      r1 = v.rep ? ((c - 1) % b) + 1 : c;
      exp_tick = (v.len > 0) && (v.abort_cyc < 0 || c < v.abort_cyc) && (r1 <= np) && (r1 % p == 0);
      if (exp_tick) begin
        k       = r1 / p - 1;
        s_sym   = v.syms[4*k +: 4];
        s_valid = v.mask[k];
      end else begin
        s_sym   = 4'($urandom_range(0, 15));
        s_valid = 1'($urandom_range(0, 1));
      end
      #1;
      check("s_ready", 32'(s_ready), 32'(exp_tick));
      if (exp_tick) begin
        e.sym = s_valid ? s_sym : 4'h0;
        e.uf  = !s_valid;
        nuf  += s_valid ? 0 : 1;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
    end
    check("sb_empty", 32'(sbq.size()), 32'(0));
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
    if (v.abort_cyc != 0) check("ucnt_total", 32'(underflow_cnt), 32'(nuf));
`endif
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_sym = 4'h0;
    cfg_period = 32'd0; cfg_burst_len = 16'd0; cfg_gap = 32'd0; cfg_repeat = 1'b0;

    //            per len rep gap mask   syms          abort poke ncyc
    vecs[0]  = '{4, 3, 1'b0, 0, 8'h07, 32'h0000_0FA5, -1, -1, 0};
    vecs[1]  = '{0, 4, 1'b0, 0, 8'h0F, 32'h0000_4321, -1, -1, 0};
    vecs[2]  = '{2, 3, 1'b0, 0, 8'h05, 32'h0000_0973, -1, -1, 0};
    vecs[3]  = '{1, 1, 1'b0, 0, 8'h01, 32'h0000_0008, -1, -1, 0};
    vecs[4]  = '{3, 0, 1'b0, 0, 8'h00, 32'h0000_0000, -1, -1, 0};
    vecs[5]  = '{5, 2, 1'b0, 0, 8'h00, 32'h0000_0021, -1, -1, 0};
    vecs[6]  = '{1, 4, 1'b0, 0, 8'h08, 32'h0000_C000, -1, -1, 0};
    vecs[7]  = '{4, 3, 1'b0, 0, 8'h07, 32'h0000_0FA5, -1,  6, 0};
    vecs[8]  = '{3, 2, 1'b1, 5, 8'h03, 32'h0000_0096, 20, -1, 0};
    vecs[9]  = '{2, 2, 1'b1, 0, 8'h03, 32'h0000_00B4,  8, -1, 0};
    vecs[10] = '{2, 2, 1'b0, 0, 8'h03, 32'h0000_0011,  0, -1, 0};
    vecs[11] = '{1, 2, 1'b0, 0, 8'h03, 32'h0000_0033,  3, -1, 0};
    vecs[12] = '{4, 3, 1'b0, 0, 8'h07, 32'h0000_0123,  6, -1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_sym", 32'(m_sym), 32'(0));
    check("rst_underflow", 32'(underflow), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_s_ready", 32'(s_ready), 32'(0));
`ifdef QAM_SCHED_UNDERFLOW_CNT_EN
    check("rst_ucnt", 32'(underflow_cnt), 32'(0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run(vecs[i]);
    end

    // Reset in the middle of a burst: nothing pending may leak out afterwards
    cfg_period = 32'd2; cfg_burst_len = 16'd5; cfg_gap = 32'd0; cfg_repeat = 1'b0;
    s_valid = 1'b1; s_sym = 4'h6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'(1));
    check("pre_rst_s_ready", 32'(s_ready), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      check("mid_rst_m_valid", 32'(m_valid), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      check("mid_rst_s_ready", 32'(s_ready), 32'(0));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
